// File: rtl/code_detector_pkg.sv
// Shared types and constants for the colour-code lock detector.
package code_detector_pkg;

   localparam int STEP_W    = 3;
   localparam int NUM_STEPS = 4;

   // Steps in order: red, blue, green, red ({R,G,B} per step, step 0 in the LSBs)
   localparam logic [STEP_W*NUM_STEPS-1:0] CODE_DEFAULT = 12'b100_010_001_100;

   typedef enum logic [2:0] {
      WAIT,
      START,
      S1,
      S2,
      S3,
      UNLOCK
   } state_t;

   typedef enum logic [1:0] {
      MATCH,
      NONE,
      WRONG
   } step_class_t;

   // Which code step a collecting state is waiting for.
   function automatic logic [1:0] step_index(input state_t s);
      case (s)
         START:   return 2'd0;
         S1:      return 2'd1;
         S2:      return 2'd2;
         S3:      return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // State reached after a correct step.
   function automatic state_t step_advance(input state_t s);
      case (s)
         START:   return S1;
         S1:      return S2;
         S2:      return S3;
         S3:      return UNLOCK;
         default: return WAIT;
      endcase
   endfunction

endpackage

// File: rtl/code_detector_step_cmp.sv
// Classifies one {R,G,B} button sample against the expected code step.
module code_detector_step_cmp
   import code_detector_pkg::*;
(
   input  logic [STEP_W-1:0] buttons,
   input  logic [STEP_W-1:0] expected,
   output step_class_t       step_class
);

   // An exact match wins even if the expected step is itself all-zero.
   always_comb begin
      step_class = WRONG;
      if (buttons == expected)
         step_class = MATCH;
      else if (buttons == '0)
         step_class = NONE;
   end

endmodule

// File: rtl/code_detector.sv
// Four-step colour-code lock detector; U pulses for one cycle after a correct code.
// Optional macro CODE_DETECTOR_IDLE_HOLD_EN: idle (no button) cycles hold the current step.
module code_detector
   import code_detector_pkg::*;
#(
   parameter logic [STEP_W*NUM_STEPS-1:0] CODE = CODE_DEFAULT
)
(
   input  logic Clk,
   input  logic Rst,
   input  logic Start,
   input  logic Red,
   input  logic Green,
   input  logic Blue,
   output logic U
);

   state_t            state_reg;
   state_t            state_next;
   logic              u_reg;
   logic [STEP_W-1:0] code_steps [NUM_STEPS];
   logic [STEP_W-1:0] expected_step;
   step_class_t       step_class;

   generate
      for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_steps
         assign code_steps[gi] = CODE[gi*STEP_W +: STEP_W];
      end
   endgenerate

   assign expected_step = code_steps[step_index(state_reg)];

   code_detector_step_cmp u_step_cmp (
      .buttons    ({Red, Green, Blue}),
      .expected   (expected_step),
      .step_class (step_class)
   );

   // Start overrides colour evaluation in every state, including UNLOCK.
   always_comb begin
      state_next = state_reg;
      if (Start) begin
         state_next = START;
      end else begin
         case (state_reg)
            WAIT:   state_next = WAIT;
            START, S1, S2, S3: begin
               case (step_class)
                  MATCH:   state_next = step_advance(state_reg);
`ifdef CODE_DETECTOR_IDLE_HOLD_EN
                  NONE:    state_next = state_reg;
`else
                  NONE:    state_next = WAIT;
`endif
                  default: state_next = WAIT;
               endcase
            end
            UNLOCK:  state_next = WAIT;
            default: state_next = WAIT;
         endcase
      end
   end

   // U is registered alongside the state so it equals (state_reg == UNLOCK) glitch-free.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg <= WAIT;
         u_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         u_reg     <= (state_next == UNLOCK);
      end
   end

   assign U = u_reg;

endmodule

// File: tb/tb_code_detector.sv
// Directed bench for code_detector: vector table, reset/priority sequences and full code sweep.
module tb_code_detector;
   import code_detector_pkg::*;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] B = 3'b001;
   localparam logic [2:0] N = 3'b000;
   localparam logic [11:0] GOOD_CODE = 12'b100_010_001_100;
`ifdef CODE_DETECTOR_IDLE_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Rst;
   logic Start;
   logic Red;
   logic Green;
   logic Blue;
   logic U;

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   code_detector dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .Start (Start),
      .Red   (Red),
      .Green (Green),
      .Blue  (Blue),
      .U     (U)
   );

   typedef struct {
      logic       start;
      logic [2:0] rgb;
      state_t     st;
      logic       u;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic s, logic [2:0] rgb, state_t st, logic u, string n);
      vec_t r;
      r.start = s;
      r.rgb   = rgb;
      r.st    = st;
      r.u     = u;
      r.name  = n;
      return r;
   endfunction

   task automatic check(string tag, logic exp_u, state_t exp_st);
      checks++;
      if (U !== exp_u) begin
         failures++;
         $display("FAIL %s: U=%0b expected %0b", tag, U, exp_u);
      end
      checks++;
      if (dut.state_reg !== exp_st) begin
         failures++;
         $display("FAIL %s: state=%0d expected %0d", tag, dut.state_reg, exp_st);
      end
   endtask

   task automatic drive(logic s, logic [2:0] rgb);
      @(negedge Clk);
      Start = s;
      {Red, Green, Blue} = rgb;
      @(posedge Clk);
      #1;
   endtask

   task automatic step(string tag, logic s, logic [2:0] rgb, state_t exp_st, logic exp_u);
      drive(s, rgb);
      check(tag, exp_u, exp_st);
      $display("%-12s start=%0b rgb=%03b -> U=%0b state=%0d", tag, s, rgb, U, dut.state_reg);
   endtask

   initial begin
      Rst = 1'b0;
      Start = 1'b0;
      {Red, Green, Blue} = 3'b000;
      #1;
      check("reset", 1'b0, WAIT);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;

      // basic unlock, one-cycle pulse, colours without Start are ignored
      vecs.push_back(v(1, N, START,  0, "basic_s"));
      vecs.push_back(v(0, R, S1,     0, "basic_r"));
      vecs.push_back(v(0, B, S2,     0, "basic_b"));
      vecs.push_back(v(0, G, S3,     0, "basic_g"));
      vecs.push_back(v(0, R, UNLOCK, 1, "basic_r2"));
      vecs.push_back(v(0, N, WAIT,   0, "pulse_end"));
      vecs.push_back(v(0, R, WAIT,   0, "nostart_r"));
      vecs.push_back(v(0, B, WAIT,   0, "nostart_b"));
      vecs.push_back(v(0, G, WAIT,   0, "nostart_g"));
      vecs.push_back(v(0, R, WAIT,   0, "nostart_r2"));
      // multiple buttons at step 0
      vecs.push_back(v(1, N, START,  0, "multi_s"));
      vecs.push_back(v(0, 3'b110, WAIT, 0, "multi_rg"));
      vecs.push_back(v(0, B, WAIT,   0, "multi_b"));
      vecs.push_back(v(0, G, WAIT,   0, "multi_g"));
      vecs.push_back(v(0, R, WAIT,   0, "multi_r"));
      // restart mid-sequence, Start beats simultaneous colour
      vecs.push_back(v(1, N, START,  0, "rst_s"));
      vecs.push_back(v(0, R, S1,     0, "rst_r"));
      vecs.push_back(v(0, B, S2,     0, "rst_b"));
      vecs.push_back(v(1, R, START,  0, "rst_s2"));
      vecs.push_back(v(0, R, S1,     0, "rst_r2"));
      vecs.push_back(v(0, B, S2,     0, "rst_b2"));
      vecs.push_back(v(0, G, S3,     0, "rst_g2"));
      vecs.push_back(v(0, R, UNLOCK, 1, "rst_r3"));
      vecs.push_back(v(0, N, WAIT,   0, "rst_end"));
      // Start while unlocked
      vecs.push_back(v(1, N, START,  0, "ul_s"));
      vecs.push_back(v(0, R, S1,     0, "ul_r"));
      vecs.push_back(v(0, B, S2,     0, "ul_b"));
      vecs.push_back(v(0, G, S3,     0, "ul_g"));
      vecs.push_back(v(0, R, UNLOCK, 1, "ul_r2"));
      vecs.push_back(v(1, N, START,  0, "ul_s2"));
      vecs.push_back(v(0, R, S1,     0, "ul_r3"));
      vecs.push_back(v(0, B, S2,     0, "ul_b3"));
      vecs.push_back(v(0, G, S3,     0, "ul_g3"));
      vecs.push_back(v(0, R, UNLOCK, 1, "ul_r4"));
      vecs.push_back(v(0, N, WAIT,   0, "ul_end"));
      // idle gap after step 0
      vecs.push_back(v(1, N, START,  0, "gap_s"));
      vecs.push_back(v(0, R, S1,     0, "gap_r"));
      vecs.push_back(v(0, N, HOLD ? S1 : WAIT, 0, "gap_idle"));
      vecs.push_back(v(0, B, HOLD ? S2 : WAIT, 0, "gap_b"));
      vecs.push_back(v(0, G, HOLD ? S3 : WAIT, 0, "gap_g"));
      vecs.push_back(v(0, R, HOLD ? UNLOCK : WAIT, HOLD, "gap_r2"));
      vecs.push_back(v(0, N, WAIT,   0, "gap_end"));
      // wrong colour at step 2 and step 3, and at step 0
      vecs.push_back(v(1, N, START,  0, "w2_s"));
      vecs.push_back(v(0, R, S1,     0, "w2_r"));
      vecs.push_back(v(0, B, S2,     0, "w2_b"));
      vecs.push_back(v(0, B, WAIT,   0, "w2_bad"));
      vecs.push_back(v(0, G, WAIT,   0, "w2_g"));
      vecs.push_back(v(1, N, START,  0, "w3_s"));
      vecs.push_back(v(0, R, S1,     0, "w3_r"));
      vecs.push_back(v(0, B, S2,     0, "w3_b"));
      vecs.push_back(v(0, G, S3,     0, "w3_g"));
      vecs.push_back(v(0, G, WAIT,   0, "w3_bad"));
      vecs.push_back(v(1, N, START,  0, "w0_s"));
      vecs.push_back(v(0, G, WAIT,   0, "w0_bad"));
      // Start held for two cycles
      vecs.push_back(v(1, N, START,  0, "hold_s"));
      vecs.push_back(v(1, B, START,  0, "hold_s2"));
      vecs.push_back(v(0, R, S1,     0, "hold_r"));
      vecs.push_back(v(0, B, S2,     0, "hold_b"));
      vecs.push_back(v(0, G, S3,     0, "hold_g"));
      vecs.push_back(v(0, R, UNLOCK, 1, "hold_r2"));
      vecs.push_back(v(0, N, WAIT,   0, "hold_end"));

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].name, vecs[i].start, vecs[i].rgb, vecs[i].st, vecs[i].u);

      // asynchronous reset after S2, then a fresh sequence is required
      step("ar_s", 1, N, START, 0);
      step("ar_r", 0, R, S1, 0);
      step("ar_b", 0, B, S2, 0);
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check("ar_async", 1'b0, WAIT);
      $display("ar_async     Rst low mid-cycle -> U=%0b state=%0d", U, dut.state_reg);
      @(negedge Clk);
      Rst = 1'b1;
      step("ar_g", 0, G, WAIT, 0);
      step("ar_r2", 0, R, WAIT, 0);
      step("ar_s2", 1, N, START, 0);
      step("ar_r3", 0, R, S1, 0);
      step("ar_b3", 0, B, S2, 0);
      step("ar_g3", 0, G, S3, 0);
      step("ar_r4", 0, R, UNLOCK, 1);
      // reset while unlocked drops U without a clock edge
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check("ar_unlock", 1'b0, WAIT);
      $display("ar_unlock    Rst low in UNLOCK -> U=%0b state=%0d", U, dut.state_reg);
      @(negedge Clk);
      Rst = 1'b1;

      // every combination of four steps after a Start pulse
      begin
         int sweep_fail;
         sweep_fail = 0;
         for (int c = 0; c < 4096; c++) begin
            logic [11:0] cv;
            logic        exp_u;
            cv = c[11:0];
            exp_u = (cv == GOOD_CODE);
            drive(1, N);
            for (int k = 0; k < 4; k++)
               drive(0, cv[3*k +: 3]);
            checks++;
            if (U !== exp_u) begin
               failures++;
               sweep_fail++;
               $display("FAIL sweep code=%03x: U=%0b expected %0b", cv, U, exp_u);
            end
         end
         $display("sweep        4096 codes, %0d wrong", sweep_fail);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
